// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with guarded digit updates
// and a free-running BCD auto-counter with wrap pulse.
module seg7_scan_ctrl #(
  parameter int DWELL_CYC = 1000,
  parameter int BLANK_CYC = 16,
  parameter int TICK_DIV  = 25000
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       upd_valid,
  output logic       upd_ready,
  input  logic [1:0] upd_digit,
  input  logic [3:0] upd_value,
  input  logic       count_en,
  output logic [6:0] seg_o,
  output logic [3:0] dig_o,
  output logic       ovf_o
);
  localparam int MAXC = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int PW   = $clog2(TICK_DIV);

  typedef enum logic {BLANK, DRIVE} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt, cnt_nxt;
  logic [1:0]         idx, idx_nxt;
  logic [PW-1:0]      pre, pre_nxt;
  logic [3:0][3:0]    d, d_nxt;
  logic               ovf_nxt, tick, accept, carry;

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0:    decode = 7'b0000001;
      4'd1:    decode = 7'b1001111;
      4'd2:    decode = 7'b0010010;
      4'd3:    decode = 7'b0000110;
      4'd4:    decode = 7'b1001100;
      4'd5:    decode = 7'b0100100;
      4'd6:    decode = 7'b0100000;
      4'd7:    decode = 7'b0001111;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0000100;
      default: decode = 7'b1111111;
    endcase
  endfunction

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= BLANK;
      cnt   <= '0;
      idx   <= '0;
      pre   <= PW'(TICK_DIV - 1);
      d     <= '0;
      ovf_o <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      pre   <= pre_nxt;
      d     <= d_nxt;
      ovf_o <= ovf_nxt;
    end
  end

  // Scan timing depends only on its own counter, never on updates or counting.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CW'(1);
    idx_nxt   = idx;
    upd_ready = 1'b0;
    seg_o     = 7'b1111111;
    dig_o     = 4'b0000;
    case (state)
      BLANK: begin
        upd_ready = 1'b1;
        if (cnt == CW'(BLANK_CYC - 1)) begin
          state_nxt = DRIVE;
          cnt_nxt   = '0;
        end
      end
      DRIVE: begin
        dig_o = 4'b0001 << idx;
        seg_o = decode(d[idx]);
        if (cnt == CW'(DWELL_CYC - 1)) begin
          state_nxt = BLANK;
          cnt_nxt   = '0;
          idx_nxt   = idx + 2'd1;
        end
      end
      default: ;
    endcase
  end

  // An accepted write wins over a coincident tick; that tick is lost.
  always_comb begin
    tick    = count_en && (pre == '0);
    accept  = upd_valid && upd_ready;
    pre_nxt = (!count_en || pre == '0) ? PW'(TICK_DIV - 1) : pre - PW'(1);
    d_nxt   = d;
    ovf_nxt = 1'b0;
    carry   = 1'b0;
    if (accept) begin
      d_nxt[upd_digit] = upd_value;
    end else if (tick) begin
      carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (d[i] >= 4'd9) d_nxt[i] = 4'd0;
          else begin
            d_nxt[i] = d[i] + 4'd1;
            carry    = 1'b0;
          end
        end
      end
      ovf_nxt = carry;
    end
  end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: a time-based reference model pushes the
// expected outputs of every cycle, a monitor pops and compares on the falling edge.
module tb_seg7_scan_ctrl;
  localparam int DW = 4, BW = 2, TD = 5, SLOT = DW + BW;

  logic       clk = 1'b0, rst = 1'b1;
  logic       upd_valid = 1'b0, count_en = 1'b0;
  logic [1:0] upd_digit = '0;
  logic [3:0] upd_value = '0;
  logic       upd_ready, ovf_o;
  logic [6:0] seg_o;
  logic [3:0] dig_o;

  seg7_scan_ctrl #(.DWELL_CYC(DW), .BLANK_CYC(BW), .TICK_DIV(TD)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_digit(upd_digit), .upd_value(upd_value), .count_en(count_en),
    .seg_o(seg_o), .dig_o(dig_o), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [12:0] exp_q[$];
  logic [6:0]  seg_tab[16];
  logic [3:0]  md[4];
  int          t_cur = 0, en_run = 0;

  initial begin
    seg_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100,
                7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111,
                7'b1111111};
  end

  // Reference model: scan position is plain arithmetic on the cycle count since reset.
  initial begin
    logic m_ovf, carry, acc, tick;
    logic [3:0] edig;
    logic [6:0] eseg;
    logic       erdy;
    int phase, slot;
    for (int i = 0; i < 4; i++) md[i] = 4'd0;
    forever begin
      @(posedge clk);
      m_ovf = 1'b0;
      if (rst) begin
        t_cur = 0; en_run = 0;
        for (int i = 0; i < 4; i++) md[i] = 4'd0;
      end else begin
        acc    = upd_valid && ((t_cur % SLOT) < BW);
        en_run = count_en ? en_run + 1 : 0;
        tick   = count_en && (en_run % TD == 0);
        if (acc) md[upd_digit] = upd_value;
        else if (tick) begin
          carry = 1'b1;
          for (int i = 0; i < 4 && carry; i++) begin
            if (md[i] >= 4'd9) md[i] = 4'd0;
            else begin md[i] = md[i] + 4'd1; carry = 1'b0; end
          end
          m_ovf = carry;
        end
        t_cur++;
      end
      phase = t_cur % SLOT;
      slot  = (t_cur / SLOT) % 4;
      if (phase < BW) begin
        edig = 4'b0000; eseg = 7'b1111111; erdy = 1'b1;
      end else begin
        edig = 4'(1 << slot); eseg = seg_tab[md[slot]]; erdy = 1'b0;
      end
      exp_q.push_back({erdy, m_ovf, edig, eseg});
    end
  end

  // Monitor
  initial begin
    logic [12:0] e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {upd_ready, ovf_o, dig_o, seg_o};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL outputs @%0t: got rdy=%b ovf=%b dig=%b seg=%b, want rdy=%b ovf=%b dig=%b seg=%b",
                   $time, a[12], a[11], a[10:7], a[6:0], e[12], e[11], e[10:7], e[6:0]);
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_digit(input logic [1:0] dg, input logic [3:0] v);
    int n = 0;
    bit done = 0;
    upd_digit = dg; upd_value = v; upd_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (upd_ready) done = 1;
      else if (++n > 50) begin
        checks++; errors++;
        $display("FAIL write_timeout: got no upd_ready in %0d cycles, want ready within %0d", n, SLOT);
        done = 1;
      end
    end
    @(posedge clk); #1;
    upd_valid = 1'b0;
  endtask

  // Wait until the current cycle sits at a given phase (and optionally slot) of the scan.
  task automatic wait_pos(input int ph, input int sl);
    int n = 0;
    while (!((t_cur % SLOT) == ph && (sl < 0 || (t_cur / SLOT) % 4 == sl))) begin
      cycles(1);
      if (++n > 200) begin
        checks++; errors++;
        $display("FAIL wait_pos: got no phase %0d slot %0d, want it within 200 cycles", ph, sl);
        return;
      end
    end
  endtask

  initial begin
    int r;
    // reset and first scan with all digits zero
    cycles(3); rst = 1'b0;
    cycles(30);
    // step d[0] through every decodable value, one full scan each
    for (int v = 0; v < 10; v++) begin
      write_digit(2'd0, 4'(v));
      cycles(26);
    end
    // 9999 rolls over with ovf, then counts to 0001
    for (int i = 0; i < 4; i++) write_digit(2'(i), 4'd9);
    count_en = 1'b1; cycles(10); count_en = 1'b0;
    cycles(24);
    // 0019: write 7 to d[2] on the tick edge -> 0719, next tick 0720
    write_digit(2'd3, 4'd0); write_digit(2'd2, 4'd0);
    write_digit(2'd1, 4'd1); write_digit(2'd0, 4'd9);
    wait_pos(BW, -1);
    count_en = 1'b1; cycles(4);
    upd_digit = 2'd2; upd_value = 4'd7; upd_valid = 1'b1;
    cycles(1); upd_valid = 1'b0;
    cycles(5); count_en = 1'b0;
    cycles(24);
    // invalid value in d[3] shows blank, carry into it wraps with ovf
    write_digit(2'd3, 4'd12); cycles(26);
    for (int i = 0; i < 3; i++) write_digit(2'(i), 4'd9);
    count_en = 1'b1; cycles(5); count_en = 1'b0;
    cycles(26);
    // reset in 3rd drive cycle of slot 2 with an update pending
    write_digit(2'd2, 4'd5);
    wait_pos(BW, 2);
    upd_digit = 2'd1; upd_value = 4'd3; upd_valid = 1'b1;
    cycles(2); rst = 1'b1;
    cycles(1); rst = 1'b0; upd_valid = 1'b0;
    cycles(26);
    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      r = $urandom_range(0, 9);
      if (r < 4) write_digit(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
      else if (r < 6) begin count_en = 1'($urandom_range(0, 1)); cycles(1); end
      else if (r < 9) cycles($urandom_range(1, 8));
      else if ($urandom_range(0, 3) == 0) begin
        rst = 1'b1; cycles($urandom_range(1, 2)); rst = 1'b0; cycles(1);
      end else cycles(1);
    end
    count_en = 1'b0;
    cycles(3);
    @(negedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 SHALL have parameter DWELL_CYC, default 1000: number of cycles one digit is driven per scan slot (legal range >=1).
REQ-002 SHALL have parameter BLANK_CYC, default 16: number of all-off guard cycles between slots (legal range >=1).
REQ-003 SHALL have parameter TICK_DIV, default 25000: number of cycles per auto-count increment (legal range >=2).
REQ-004 SHALL have port wb_clk_i, input, width 1: single clock, rising edge.
REQ-005 SHALL have port wb_rst_i, input, width 1: synchronous reset, active-high.
REQ-006 SHALL have port upd_valid, input, width 1: digit-update request.
REQ-007 SHALL have port upd_ready, output, width 1: update accepted this cycle when high together with upd_valid.
REQ-008 SHALL have port upd_digit, input, width 2: index of the target digit.
REQ-009 SHALL have port upd_value, input, width 4: new digit value.
REQ-010 SHALL have port count_en, input, width 1: enables the BCD auto-count.
REQ-011 SHALL have port seg_o, output, width 7: active-low segments ordered {a,b,c,d,e,f,g}, with a at bit 6.
REQ-012 SHALL have port dig_o, output, width 4: active-high one-hot digit enable.
REQ-013 SHALL have port ovf_o, output, width 1: one-cycle pulse on a 9999->0000 wrap.

Function
REQ-014 SHALL hold four 4-bit digit registers, d[0]..d[3], with d[0] least significant.
REQ-015 SHALL implement a scan FSM with two states, BLANK and DRIVE, plus a 2-bit slot index idx.
REQ-016 SHALL remain in BLANK for exactly BLANK_CYC cycles and then enter DRIVE.
REQ-017 SHALL remain in DRIVE for exactly DWELL_CYC cycles, then enter BLANK with idx advanced by 1 modulo 4.
REQ-018 SHALL, in BLANK, drive seg_o=7'b1111111 and dig_o=4'b0000.
REQ-019 SHALL, in DRIVE, drive dig_o=1<<idx and seg_o=decode(d[idx]).
REQ-020 SHALL derive seg_o and dig_o only from registered state, with no input-to-output combinational path.
REQ-021 SHALL decode as follows: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, 10..15=1111111 (blank).
REQ-022 SHALL assert upd_ready only while the FSM is in BLANK, so the display never changes mid-slot.
REQ-023 SHALL write upd_value into d[upd_digit] at the clock edge where upd_valid and upd_ready are both high.
REQ-024 SHALL hold an unaccepted request pending without loss; the requester keeps upd_valid and its fields stable until accepted.
REQ-025 SHALL run a prescaler only while count_en=1, counting TICK_DIV-1 down to 0, then issuing a one-cycle tick and reloading.
REQ-026 SHALL reload the prescaler to TICK_DIV-1 whenever count_en=0, so the first tick comes TICK_DIV cycles after count_en rises.
REQ-027 SHALL, on a tick, increment {d3,d2,d1,d0} in BCD: a digit >=9 becomes 0 and carries; a digit <9 increments and stops the carry.
REQ-028 SHALL, when a tick carries out of d[3], pulse ovf_o high for exactly the cycle in which the register update occurs.
REQ-029 SHALL, when a tick and an accepted update occur in the same cycle, apply the update and drop the tick; no digit changes due to that tick and ovf_o stays 0.
REQ-030 SHALL keep the scan FSM timing independent of updates and count activity.

Reset
REQ-031 SHALL, with wb_rst_i high at a clock edge, set state=BLANK, idx=0, blank counter=0, dwell counter=0, prescaler=TICK_DIV-1, d[0..3]=0, and ovf_o=0.
REQ-032 SHALL drive seg_o=7'b1111111, dig_o=0 and upd_ready=1 while in reset.
REQ-033 SHALL let reset asserted mid-slot or mid-count abort the operation immediately at that edge, discarding any pending update.
REQ-034 SHALL, after reset deasserts, enter DRIVE with idx=0 on the BLANK_CYC-th cycle.

Verification (DWELL_CYC=4, BLANK_CYC=2, TICK_DIV=5)
REQ-035 SHALL cover reset release with all digits 0 -> BLANK for 2 cycles, then dig_o=0001 with seg_o=0000001 for 4 cycles, then 2 blank cycles, then dig_o=0010.
REQ-036 SHALL cover writing 0..9 into d[0] one at a time, each held until accepted -> seg_o during each digit-0 slot steps through the REQ-021 table, and no write is accepted in DRIVE.
REQ-037 SHALL cover d=9999 with count_en=1 -> after 5 cycles d=0000 with ovf_o high for 1 cycle; after 5 more cycles d=0001.
REQ-038 SHALL cover a write of 7 to d[2] landing on a tick cycle with d=0019 -> d=0719 (tick dropped); the next tick gives 0720.
REQ-039 SHALL cover writing 12 to d[3] -> digit-3 slot shows 1111111; a carry into d[3] gives 0 with ovf_o=1.
REQ-040 SHALL cover reset asserted in the 3rd DRIVE cycle of slot 2 with upd_valid pending -> next cycle outputs are blank, d=0000, idx=0, and the pending update is discarded.
